// File: rtl/clk_divider_prog.sv
// ----------------------------------------------------------------------------
// clk_divider_prog
//
// Runtime-programmable integer clock divider. Produces f_out at clk/N, where
// N can be reloaded while the divider is running, plus a one-cycle tick
// strobe in the cycle f_out rises. A newly requested ratio is held pending
// and only takes effect at a period boundary, so f_out never shows a runt
// pulse. While idle (en=0) a pending ratio is applied on the next edge.
//
// Optional build macro: DIV_HALF_DUTY_EN
//   When defined, odd ratios use a shorter posedge high time plus a negedge
//   flop so f_out is exactly 50% duty. When undefined, odd N gives
//   (N+1)/2 high cycles and (N-1)/2 low cycles.
//
// Parameters:
//   CNT_W        width of the ratio and internal counter (max N = 2^CNT_W-1)
//   DEFAULT_DIV  ratio in effect after reset (2..2^CNT_W-1)
//
// Ports:
//   clk           in   system clock, rising-edge logic
//   rst           in   asynchronous active-low reset
//   en            in   divider run enable
//   div_val       in   requested ratio N (values below 2 are clamped to 2)
//   div_load      in   one-cycle request to capture div_val
//   load_pending  out  captured ratio waiting for the next period boundary
//   div_cur       out  ratio currently in effect
//   f_out         out  divided clock
//   tick          out  one-cycle pulse in the cycle f_out rises
// ----------------------------------------------------------------------------
module clk_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             load_pending,
    output logic [CNT_W-1:0] div_cur,
    output logic             f_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend_val;
    logic             f_pos;

    logic             wrap;
    logic             apply_run;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] h_nxt;

    // Ratios below 2 cannot form a period with both a high and a low phase.
    function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] n);
        return (n < TWO) ? TWO : n;
    endfunction

`ifdef DIV_HALF_DUTY_EN
    // floor(N/2): odd ratios get the extra half cycle from the negedge flop.
    function automatic logic [CNT_W-1:0] high_time(input logic [CNT_W-1:0] n);
        return n >> 1;
    endfunction
`else
    // ceil(N/2), computed one bit wider so N = 2^CNT_W-1 does not overflow.
    function automatic logic [CNT_W-1:0] high_time(input logic [CNT_W-1:0] n);
        logic [CNT_W:0] up;
        up = {1'b0, n} + {{CNT_W{1'b0}}, 1'b1};
        return up[CNT_W:1];
    endfunction
`endif

    always_comb begin
        wrap      = (cnt == (div_cur - ONE));
        apply_run = wrap & load_pending;
        div_nxt   = apply_run ? pend_val : div_cur;
        cnt_nxt   = wrap ? '0 : (cnt + ONE);
        // High time is taken from the ratio that governs the next count.
        h_nxt     = high_time(div_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= DEF_DIV - ONE;
            div_cur      <= DEF_DIV;
            pend_val     <= '0;
            load_pending <= 1'b0;
            f_pos        <= 1'b0;
            tick         <= 1'b0;
        end else begin
            // Last request wins; a load coinciding with an apply becomes the
            // next pending value, since apply uses the pre-edge pend_val.
            if (div_load) begin
                pend_val <= clamp_ratio(div_val);
            end

            if (en) begin
                cnt   <= cnt_nxt;
                f_pos <= (cnt_nxt < h_nxt);
                tick  <= (cnt_nxt == '0);
                if (apply_run) begin
                    div_cur <= pend_val;
                end
                load_pending <= div_load | (load_pending & ~wrap);
            end else begin
                // Park the counter at the last count so the first enabled
                // edge wraps to 0 and restarts the phase.
                f_pos <= 1'b0;
                tick  <= 1'b0;
                if (load_pending) begin
                    div_cur <= pend_val;
                    cnt     <= pend_val - ONE;
                end else begin
                    cnt     <= div_cur - ONE;
                end
                load_pending <= div_load;
            end
        end
    end

`ifdef DIV_HALF_DUTY_EN
    logic f_neg;

    // Half-cycle extension of the posedge pulse, only for odd ratios.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            f_neg <= 1'b0;
        end else begin
            f_neg <= f_pos & div_cur[0];
        end
    end

    assign f_out = f_pos | f_neg;
`else
    assign f_out = f_pos;
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// ----------------------------------------------------------------------------
// tb_clk_divider_prog
//
// Directed bench for clk_divider_prog (CNT_W=8, DEFAULT_DIV=4). Outputs are
// sampled 1 ns after each rising edge and again 1 ns after each falling
// edge, so the half-cycle behaviour of odd ratios is visible.
// ----------------------------------------------------------------------------
module tb_clk_divider_prog;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic             load_pending;
    logic [CNT_W-1:0] div_cur;
    logic             f_out;
    logic             tick;

    int n_checks = 0;
    int n_fail   = 0;

    clk_divider_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .div_val      (div_val),
        .div_load     (div_load),
        .load_pending (load_pending),
        .div_cur      (div_cur),
        .f_out        (f_out),
        .tick         (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that set cnt=0 for ratio n. Checks ncyc
    // cycles on both clock phases; ncyc is a multiple of n, so it leaves the
    // divider at the start of a fresh period.
    task automatic run_check(input string tag, input int n, input int ncyc);
        int hp;
        int hn;
        hp = (n + 1) / 2;
`ifdef DIV_HALF_DUTY_EN
        hn = n / 2;
`else
        hn = (n + 1) / 2;
`endif
        check_val({tag, "_div_cur"}, div_cur, n);
        for (int i = 0; i < ncyc; i++) begin
            check_val({tag, "_f_pos"}, f_out, ((i % n) < hp) ? 1 : 0);
            check_val({tag, "_tick"}, tick, ((i % n) == 0) ? 1 : 0);
            #5;
            check_val({tag, "_f_neg"}, f_out, ((i % n) < hn) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        div_val  = '0;
        div_load = 1'b0;

        // Reset held.
        repeat (3) step();
        check_val("rst_f_out", f_out, 0);
        check_val("rst_tick", tick, 0);
        check_val("rst_pending", load_pending, 0);
        check_val("rst_div_cur", div_cur, 4);

        // Release with en=1: first edge restarts at phase 0.
        rst = 1'b1;
        en  = 1'b1;
        step();
        run_check("div4", 4, 8);

        // Load 6 at cnt=1; stays pending until the wrap.
        step();
        div_val  = 8'd6;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check_val("ld6_pending_a", load_pending, 1);
        check_val("ld6_div_cur_a", div_cur, 4);
        step();
        check_val("ld6_pending_b", load_pending, 1);
        check_val("ld6_f_out_b", f_out, 0);
        step();
        check_val("ld6_pending_c", load_pending, 0);
        run_check("div6", 6, 12);

        // Odd ratio 5.
        div_val  = 8'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        repeat (5) step();
        run_check("div5", 5, 10);

        // div_val=1 clamps to 2.
        div_val  = 8'd1;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        repeat (4) step();
        run_check("clamp1", 2, 4);

        // Move to 3 so the clamp of 0 is observable.
        div_val  = 8'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        run_check("div3", 3, 6);

        // div_val=0 clamps to 2.
        div_val  = 8'd0;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        repeat (2) step();
        run_check("clamp0", 2, 4);

        // Load on the wrap edge with nothing pending: deferred one period.
        step();
        div_val  = 8'd8;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check_val("wrapld_div_cur_a", div_cur, 2);
        check_val("wrapld_pending_a", load_pending, 1);
        step();
        step();
        check_val("wrapld_div_cur_b", div_cur, 8);
        check_val("wrapld_pending_b", load_pending, 0);
        check_val("wrapld_tick_b", tick, 1);

        // Drop en at cnt=2 with N=8.
        step();
        step();
        check_val("endrop_f_before", f_out, 1);
        en = 1'b0;
        step();
        check_val("endrop_f_after", f_out, 0);
        check_val("endrop_tick", tick, 0);

        // Load while idle: applied on the following edge.
        div_val  = 8'd10;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check_val("idle_pending_a", load_pending, 1);
        step();
        check_val("idle_div_cur", div_cur, 10);
        check_val("idle_pending_b", load_pending, 0);
        check_val("idle_f_out", f_out, 0);

        // Re-enable: f_out and tick high on the first edge.
        en = 1'b1;
        step();
        run_check("div10", 10, 10);

        // Asynchronous reset mid-period with a load pending.
        div_val  = 8'd3;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        check_val("arst_pre_pending", load_pending, 1);
        check_val("arst_pre_f_out", f_out, 1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_f_out", f_out, 0);
        check_val("arst_tick", tick, 0);
        check_val("arst_pending", load_pending, 0);
        check_val("arst_div_cur", div_cur, 4);
        step();
        rst = 1'b1;
        step();
        run_check("post_rst", 4, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
